// File: rtl/decode_multi_pkg.sv
// rv32i_types: decode class enum, RV32I opcodes and decode_multi defaults (no ports)
package rv32i_types;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_AGE_BITS = 16;
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_CSR,
    CLS_ILLEGAL
  } decode_class_t;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
endpackage

// File: rtl/decode_multi_lane.sv
// decode_lane: one-instruction RV32I decoder; in valid/inst, out cls/imm/rs1/rs2/rd/we/illegal/mem
module decode_lane import rv32i_types::*; (
  input  logic          valid,
  input  logic [31:0]   inst,
  output decode_class_t cls,
  output logic [31:0]   imm,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [4:0]    rd,
  output logic          we,
  output logic          illegal,
  output logic          mem
);
  logic [6:0] op;
  logic       no_rs1;
  logic       no_rs2;
  always_comb begin
    op = inst[6:0];
    cls = !valid ? CLS_ALU :
          (op == OP_LUI || op == OP_AUIPC || op == OP_IMM || op == OP_REG) ? CLS_ALU :
          op == OP_BR ? CLS_BRANCH :
          (op == OP_JAL || op == OP_JALR) ? CLS_JUMP :
          op == OP_LOAD ? CLS_LOAD :
          op == OP_STORE ? CLS_STORE :
          op == OP_CSR ? CLS_CSR : CLS_ILLEGAL;
    no_rs1 = op == OP_LUI || op == OP_AUIPC || op == OP_JAL;
    no_rs2 = no_rs1 || op == OP_JALR || op == OP_LOAD || op == OP_IMM;
    we = valid && (cls == CLS_ALU || cls == CLS_JUMP || cls == CLS_LOAD);
    illegal = cls == CLS_ILLEGAL;
    mem = cls == CLS_LOAD || cls == CLS_STORE;
    rs1 = (valid && !no_rs1) ? inst[19:15] : '0;
    rs2 = (valid && !no_rs2) ? inst[24:20] : '0;
    rd = we ? inst[11:7] : '0;
    imm = !valid ? '0 :
          (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? {{20{inst[31]}}, inst[31:20]} :
          op == OP_STORE ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
          op == OP_BR ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
          (op == OP_LUI || op == OP_AUIPC) ? {inst[31:12], 12'h000} :
          op == OP_JAL ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : '0;
  end
endmodule

// File: rtl/decode_multi.sv
// decode_multi: WIDTH-lane registered decode with mem age tagging; in fetch group/flush/out_ready, out decoded group/in_ready/age_count
module decode_multi import rv32i_types::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AGE_BITS = DEF_AGE_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      branch_mispredict,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_lane_valid,
  input  logic [WIDTH*64-1:0]       in_packet,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_lane_valid,
  output logic [WIDTH*32-1:0]       out_pc,
  output logic [WIDTH*32-1:0]       out_inst,
  output logic [WIDTH*3-1:0]        out_class,
  output logic [WIDTH*32-1:0]       out_imm,
  output logic [WIDTH*5-1:0]        out_rs1_addr,
  output logic [WIDTH*5-1:0]        out_rs2_addr,
  output logic [WIDTH*5-1:0]        out_rd_addr,
  output logic [WIDTH-1:0]          out_regf_we,
  output logic [WIDTH*AGE_BITS-1:0] out_mem_age,
  output logic [WIDTH-1:0]          out_illegal,
  output logic [AGE_BITS-1:0]       age_count
);
  decode_class_t       cls [WIDTH];
  logic [31:0]         imm [WIDTH];
  logic [4:0]          rs1 [WIDTH];
  logic [4:0]          rs2 [WIDTH];
  logic [4:0]          rd  [WIDTH];
  logic [AGE_BITS-1:0] age [WIDTH];
  logic [WIDTH-1:0]    we;
  logic [WIDTH-1:0]    ill;
  logic [WIDTH-1:0]    mem;
  logic [AGE_BITS-1:0] age_sum;
  logic [2:0]          n;
  logic                accept;
  assign in_ready = (!out_valid || out_ready) && !branch_mispredict;
  assign accept = in_valid && in_ready;
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    decode_lane u_lane (
      .valid   (in_lane_valid[g]),
      .inst    (in_packet[g*64 +: 32]),
      .cls     (cls[g]),
      .imm     (imm[g]),
      .rs1     (rs1[g]),
      .rs2     (rs2[g]),
      .rd      (rd[g]),
      .we      (we[g]),
      .illegal (ill[g]),
      .mem     (mem[g])
    );
  end
  // n walks the lanes oldest-first, so each mem lane sees the count of older mem lanes
  always_comb begin
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      age[i] = mem[i] ? age_count + AGE_BITS'(n) : '0;
      n = n + 3'(mem[i]);
    end
    age_sum = age_count + AGE_BITS'(n);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      out_pc         <= '0;
      out_inst       <= '0;
      out_class      <= '0;
      out_imm        <= '0;
      out_rs1_addr   <= '0;
      out_rs2_addr   <= '0;
      out_rd_addr    <= '0;
      out_regf_we    <= '0;
      out_mem_age    <= '0;
      out_illegal    <= '0;
      age_count      <= '0;
    end else if (branch_mispredict) begin
      out_valid <= 1'b0;
      age_count <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_lane_valid <= in_lane_valid;
      out_regf_we    <= we;
      out_illegal    <= ill;
      age_count      <= age_sum;
      for (int i = 0; i < WIDTH; i++) begin
        out_pc[i*32 +: 32]                <= in_packet[i*64+32 +: 32];
        out_inst[i*32 +: 32]              <= in_packet[i*64 +: 32];
        out_class[i*3 +: 3]               <= cls[i];
        out_imm[i*32 +: 32]               <= imm[i];
        out_rs1_addr[i*5 +: 5]            <= rs1[i];
        out_rs2_addr[i*5 +: 5]            <= rs2[i];
        out_rd_addr[i*5 +: 5]             <= rd[i];
        out_mem_age[i*AGE_BITS +: AGE_BITS] <= age[i];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
